// File: rtl/traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : traffic_intersection_ctrl
// Brief   : Two-road intersection sequencer with vehicle/pedestrian demand.
// Revision: 1.0
// ============================================================================
module traffic_intersection_ctrl #(
  parameter int green_tics     = 20,
  parameter int amber_tics     = 3,
  parameter int allred_tics    = 2,
  parameter int min_green_tics = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tic,
  input  logic       ew_sensor,
  input  logic       ped_button,
  output logic       ns_red,
  output logic       ns_amber,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_amber,
  output logic       ew_green,
  output logic       walk,
  output logic [2:0] state
);

  localparam logic [2:0] S_NS_GREEN  = 3'd0;
  localparam logic [2:0] S_NS_AMBER  = 3'd1;
  localparam logic [2:0] S_ALL_RED_A = 3'd2;
  localparam logic [2:0] S_EW_GREEN  = 3'd3;
  localparam logic [2:0] S_EW_AMBER  = 3'd4;
  localparam logic [2:0] S_ALL_RED_B = 3'd5;

  localparam logic [7:0] c_GREEN_LAST  = 8'(green_tics - 1);
  localparam logic [7:0] c_AMBER_LAST  = 8'(amber_tics - 1);
  localparam logic [7:0] c_ALLRED_LAST = 8'(allred_tics - 1);
  localparam logic [7:0] c_MING_LAST   = 8'(min_green_tics - 1);

  // Lamp vector order: {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green}
  localparam logic [5:0] c_LAMPS_ALLRED = 6'b100_100;

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [7:0] r_timer;
  logic       r_veh_pend;
  logic       r_ped_pend;
  logic       r_walk;
  logic [5:0] r_lamps;
  logic [5:0] w_lamps;
  logic       w_entry;
  logic       w_enter_ewg;

  assign w_entry     = (w_next_state != r_state);
  assign w_enter_ewg = w_entry && (w_next_state == S_EW_GREEN);

  // State, timer, demand latches and registered lamps
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_ALL_RED_B;
      r_timer    <= 8'd0;
      r_veh_pend <= 1'b0;
      r_ped_pend <= 1'b0;
      r_walk     <= 1'b0;
      r_lamps    <= c_LAMPS_ALLRED;
    end else begin
      r_state <= w_next_state;
      r_lamps <= w_lamps;
      if (w_entry) begin
        r_timer <= 8'd0;
      end else if (tic && (r_timer != 8'hFF)) begin
        r_timer <= r_timer + 8'd1;
      end
      // Clearing on EW_GREEN entry beats a same-cycle request
      r_veh_pend <= w_enter_ewg ? 1'b0 : (r_veh_pend | ew_sensor);
      r_ped_pend <= w_enter_ewg ? 1'b0 : (r_ped_pend | ped_button);
      r_walk     <= (w_next_state == S_EW_GREEN) && (w_enter_ewg ? r_ped_pend : r_walk);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_NS_GREEN:
        if (tic && (r_timer >= c_MING_LAST) && (r_veh_pend || r_ped_pend))
          w_next_state = S_NS_AMBER;
      S_NS_AMBER:
        if (tic && (r_timer == c_AMBER_LAST)) w_next_state = S_ALL_RED_A;
      S_ALL_RED_A:
        if (tic && (r_timer == c_ALLRED_LAST)) w_next_state = S_EW_GREEN;
      S_EW_GREEN:
        if (tic && (r_timer == c_GREEN_LAST)) w_next_state = S_EW_AMBER;
      S_EW_AMBER:
        if (tic && (r_timer == c_AMBER_LAST)) w_next_state = S_ALL_RED_B;
      S_ALL_RED_B:
        if (tic && (r_timer == c_ALLRED_LAST)) w_next_state = S_NS_GREEN;
      default:
        w_next_state = S_ALL_RED_B;
    endcase
  end

  // Lamps are decoded from the upcoming state so the registered copy tracks r_state
  always_comb begin
    w_lamps = c_LAMPS_ALLRED;
    case (w_next_state)
      S_NS_GREEN: w_lamps = 6'b001_100;
      S_NS_AMBER: w_lamps = 6'b010_100;
      S_EW_GREEN: w_lamps = 6'b100_001;
      S_EW_AMBER: w_lamps = 6'b100_010;
      default:    w_lamps = c_LAMPS_ALLRED;
    endcase
  end

  assign {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green} = r_lamps;
  assign walk  = r_walk;
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_traffic_intersection_ctrl
// Brief   : Directed scenarios plus random traffic against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_traffic_intersection_ctrl;

  localparam int GREEN  = 20;
  localparam int AMBER  = 3;
  localparam int ALLRED = 2;
  localparam int MING   = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tic = 1'b0;
  logic       ew_sensor = 1'b0;
  logic       ped_button = 1'b0;
  logic       ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk;
  logic [2:0] state;

  traffic_intersection_ctrl #(
    .green_tics(GREEN), .amber_tics(AMBER),
    .allred_tics(ALLRED), .min_green_tics(MING)
  ) dut (
    .clock(clock), .reset(reset), .tic(tic), .ew_sensor(ew_sensor),
    .ped_button(ped_button), .ns_red(ns_red), .ns_amber(ns_amber),
    .ns_green(ns_green), .ew_red(ew_red), .ew_amber(ew_amber),
    .ew_green(ew_green), .walk(walk), .state(state)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state = 5, m_timer = 0, m_nx = 0;
  bit m_veh = 0, m_ped = 0, m_walk = 0, m_valid = 0, m_ex = 0;

  function automatic int dur(input int s);
    case (s)
      1, 4:    return AMBER;
      2, 5:    return ALLRED;
      3:       return GREEN;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_lamps(input int s);
    int ns, ew;
    ns = (s == 0) ? 1 : (s == 1) ? 2 : 4;
    ew = (s == 3) ? 1 : (s == 4) ? 2 : 4;
    return ns * 8 + ew;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_state = 5; m_timer = 0; m_veh = 0; m_ped = 0; m_walk = 0; m_valid = 1;
    end else if (m_valid) begin
      if (m_state == 0) m_ex = tic && (m_timer >= MING - 1) && (m_veh || m_ped);
      else              m_ex = tic && (m_timer == dur(m_state) - 1);
      m_nx = m_ex ? (m_state + 1) % 6 : m_state;
      if (m_ex && m_nx == 3) begin
        m_walk = m_ped; m_veh = 0; m_ped = 0;
      end else begin
        m_walk = (m_nx == 3) && m_walk;
        m_veh  = m_veh | ew_sensor;
        m_ped  = m_ped | ped_button;
      end
      if (m_ex)                       m_timer = 0;
      else if (tic && m_timer < 255)  m_timer = m_timer + 1;
      m_state = m_nx;
    end
  end

  // ---------------- per-cycle compare + visit monitor ----------------
  bit r_tic_seen = 0, r_rst_seen = 0, r_walk_tic = 0;
  int q_state[$];
  int q_cnt[$];
  int vis_cnt = 0, last_state = 5, wcnt = 0;
  bit watch_quiet = 0, quiet_bad = 0;

  always @(posedge clock) begin
    r_tic_seen = tic && !reset;
    r_rst_seen = reset;
    r_walk_tic = tic && !reset && walk;
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("state", int'(state), m_state);
      chk("lamps", int'({ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green}),
          exp_lamps(m_state));
      chk("walk", int'(walk), int'(m_walk));
    end
    if (r_rst_seen) begin
      vis_cnt = 0; last_state = int'(state);
    end else begin
      if (r_tic_seen) vis_cnt++;
      if (r_walk_tic) wcnt++;
      if (int'(state) != last_state) begin
        q_state.push_back(last_state);
        q_cnt.push_back(vis_cnt);
        vis_cnt = 0;
        last_state = int'(state);
      end
    end
    if (watch_quiet && (ew_green || walk)) quiet_bad = 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clock) tic = 1'b1;
    @(negedge clock) tic = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_ew();
    ew_sensor = 1'b1;
    @(negedge clock) ew_sensor = 1'b0;
  endtask

  task automatic pulse_ped();
    ped_button = 1'b1;
    @(negedge clock) ped_button = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock) reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_state(input int s, input int lim);
    int k = 0;
    while (int'(state) != s && k < lim) begin
      tick();
      k++;
    end
    chk("wait_state", int'(state), s);
  endtask

  task automatic run_until(input int need, input int lim);
    int k = 0;
    while (q_state.size() < need && k < lim) begin
      tick();
      k++;
    end
    chk("seq_len", int'(q_state.size() >= need), 1);
  endtask

  task automatic chk_seq(input int base, input int n, input int es[7], input int ec[7]);
    for (int i = 0; i < n; i++) begin
      if (base + i < q_state.size()) begin
        chk($sformatf("seq%0d_state", i), q_state[base + i], es[i]);
        chk($sformatf("seq%0d_tics", i), q_cnt[base + i], ec[i]);
      end
    end
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    int base, w0;
    repeat (3) @(negedge clock);
    chk("rst_state", int'(state), 5);
    chk("rst_reds", int'({ns_red, ew_red}), 3);
    chk("rst_others", int'({ns_amber, ns_green, ew_amber, ew_green, walk}), 0);
    base = q_state.size();
    reset = 1'b0;

    // Rest with no requests; long enough to saturate the timer
    watch_quiet = 1;
    repeat (270) tick();
    watch_quiet = 0;
    chk("rest_state", int'(state), 0);
    chk("rest_quiet", int'(quiet_bad), 0);
    chk_seq(base, 1, '{5, 0, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0, 0});
    pulse_ped();
    tick();
    chk("sat_exit", int'(state), 1);

    // Early vehicle request at NS_GREEN timer=3
    do_reset();
    wait_state(0, 10);
    repeat (3) tick();
    pulse_ew();
    base = q_state.size();
    w0 = wcnt;
    run_until(base + 6, 80);
    chk_seq(base, 6, '{0, 1, 2, 3, 4, 5, 0}, '{10, 3, 2, 20, 3, 2, 0});
    chk("early_walk_tics", wcnt - w0, 0);

    // Late pedestrian, request during service, 100 clocks without tic
    base = q_state.size();
    w0 = wcnt;
    repeat (50) tick();
    pulse_ped();
    tick();
    chk("late_ped_exit", int'(state), 1);
    wait_state(3, 10);
    repeat (5) tick();
    pulse_ew();
    repeat (100) @(negedge clock);
    chk("notic_hold", int'(state), 3);
    run_until(base + 7, 120);
    chk_seq(base, 7, '{0, 1, 2, 3, 4, 5, 0}, '{51, 3, 2, 20, 3, 2, 10});
    chk("late_walk_tics", wcnt - w0, 20);

    // Vehicle request on the very edge that enters EW_GREEN is discarded
    wait_state(2, 10);
    tick();
    @(negedge clock) begin tic = 1'b1; ew_sensor = 1'b1; end
    @(negedge clock) begin tic = 1'b0; ew_sensor = 1'b0; end
    @(negedge clock);
    chk("same_cycle_ewg", int'(state), 3);
    wait_state(0, 40);
    repeat (40) tick();
    chk("same_cycle_hold", int'(state), 0);

    // Reset in EW_GREEN with walk lit and a vehicle pending
    pulse_ped();
    wait_state(3, 30);
    repeat (2) tick();
    chk("pre_rst_walk", int'(walk), 1);
    pulse_ew();
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    chk("midrst_state", int'(state), 5);
    chk("midrst_walk_ewg", int'({walk, ew_green}), 0);
    chk("midrst_reds", int'({ns_red, ew_red}), 3);
    repeat (40) tick();
    chk("midrst_pend_clear", int'(state), 0);

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      tic        = ($urandom_range(0, 3) == 0);
      ew_sensor  = ($urandom_range(0, 59) == 0);
      ped_button = ($urandom_range(0, 89) == 0);
      reset      = ($urandom_range(0, 1499) == 0);
    end
    @(negedge clock) begin tic = 0; ew_sensor = 0; ped_button = 0; reset = 0; end
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 Parameter green_tics, default 20: side-road (EW) green duration, in tics.
REQ-002 Parameter amber_tics, default 3: amber duration for either road, in tics.
REQ-003 Parameter allred_tics, default 2: all-red clearance duration, in tics.
REQ-004 Parameter min_green_tics, default 10: minimum main-road (NS) green, in tics.
REQ-005 Parameter constraint: all four parameters SHALL be in the range 1..255; the 8-bit timer covers this range.
REQ-006 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port tic, input, 1: one-cycle time-base pulse; all durations are counted in tic pulses.
REQ-009 Port ew_sensor, input, 1: side-road vehicle present (level).
REQ-010 Port ped_button, input, 1: pedestrian crossing request (pulse or level).
REQ-011 Ports ns_red, ns_amber, ns_green, input to none, output, 1 each: main-road lamps.
REQ-012 Ports ew_red, ew_amber, ew_green, output, 1 each: side-road lamps.
REQ-013 Port walk, output, 1: pedestrian walk lamp, which crosses the main road.
REQ-014 Port state, output, 3: current state encoding, for debug.

Function
REQ-015 States SHALL be NS_GREEN=0, NS_AMBER=1, ALL_RED_A=2, EW_GREEN=3, EW_AMBER=4, ALL_RED_B=5; codes 6 and 7 SHALL go to ALL_RED_B on the next clock.
REQ-016 Lamps SHALL be registered and decoded from the state only:
- exactly one lamp per road is lit;
- both reds are lit in ALL_RED_A and ALL_RED_B;
- ns_red is lit whenever EW is green or amber, and ew_red is lit whenever NS is green or amber.
REQ-017 The 8-bit timer SHALL clear on every state entry and increment on each tic while in the state.
- The timer saturates at 255.
- The timer does not advance without tic.
REQ-018 A fixed-duration state of N tics SHALL exit on the clock edge where tic=1 and timer==N-1. It therefore lasts exactly N tic pulses.
REQ-019 Fixed durations SHALL be as follows.
- NS_AMBER and EW_AMBER: amber_tics.
- ALL_RED_A and ALL_RED_B: allred_tics.
- EW_GREEN: green_tics.
REQ-020 NS_GREEN SHALL be the rest state and SHALL exit to NS_AMBER only on a tic where both conditions hold:
- timer>=min_green_tics-1;
- veh_pend or ped_pend is set.
Otherwise it holds indefinitely.
REQ-021 The transition sequence SHALL be fixed: NS_GREEN -> NS_AMBER -> ALL_RED_A -> EW_GREEN -> EW_AMBER -> ALL_RED_B -> NS_GREEN.
REQ-022 veh_pend SHALL set on any cycle with ew_sensor=1 and clear on the clock entering EW_GREEN; clear wins when both occur in the same cycle.
REQ-023 ped_pend SHALL set on any cycle with ped_button=1 and clear on the clock entering EW_GREEN; clear wins when both occur in the same cycle.
REQ-024 Requests arriving during EW_GREEN, EW_AMBER or ALL_RED_B SHALL be held and served in the next cycle through the sequence.
REQ-025 walk SHALL assert on entry to EW_GREEN if ped_pend was set at entry, and SHALL deassert on exit from EW_GREEN. walk is never high outside EW_GREEN.
REQ-026 When tic and a reset both occur, reset SHALL take priority.

Reset
REQ-027 While reset=1 at a clock edge, the block SHALL load state=ALL_RED_B, timer=0, veh_pend=0, ped_pend=0 and walk=0.
- Lamps: ns_red=1, ew_red=1, all other lamps 0.
REQ-028 After reset deasserts, the block SHALL complete allred_tics of ALL_RED_B and then enter NS_GREEN.
REQ-029 Reset asserted mid-cycle in any state SHALL force the reset state on the next edge regardless of tic or pending requests.

Verification
REQ-030 Rest with no requests: apply reset, then tic every 4 clocks, no requests, for 200 tics.
- Response: ALL_RED_B for 2 tics, then NS_GREEN held for the remainder.
- ew_green=0 and walk=0 throughout.
REQ-031 Early vehicle request: with defaults, pulse ew_sensor 1 cycle at NS_GREEN timer=3.
- Response: NS_GREEN exits at its 10th tic, then NS_AMBER 3 tics, ALL_RED_A 2 tics, EW_GREEN 20 tics, EW_AMBER 3 tics, ALL_RED_B 2 tics.
- walk=0 throughout.
REQ-032 Late pedestrian request: press ped_button at NS_GREEN timer=50.
- Response: exit to NS_AMBER on the next tic.
- walk=1 for exactly the 20 EW_GREEN tics.
REQ-033 Request during service: pulse ew_sensor during EW_GREEN.
- Response: veh_pend remains 1 after the cycle.
- The next NS_GREEN lasts exactly min_green_tics tics.
REQ-034 Same-cycle set and clear, and no tic: assert ew_sensor on the same edge as entry to EW_GREEN.
- Response: veh_pend=0 afterwards.
- Also, holding tic=0 for 100 clocks in any state leaves state and timer unchanged.
REQ-035 Reset mid-operation: assert reset during EW_GREEN with walk=1.
- Response: the next edge shows ALL_RED_B, walk=0, ew_green=0, both reds=1, and both pending flags cleared.
